// File: rtl/scheduler_pkg.sv
// Shared definitions for the dequeue scheduler: FSM encoding, PIFO entry
// field positions and the one-hot port bit order.
package scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_POP    = 2'd1,
        ST_WAIT   = 2'd2,
        ST_STREAM = 2'd3
    } sched_state_e;

    localparam int unsigned PIFO_VALID_POS = 31;
    localparam int unsigned PIFO_RANK_MSB  = 30;
    localparam int unsigned PIFO_RANK_LSB  = 12;
    localparam int unsigned PIFO_ADDR_MSB  = 11;
    localparam int unsigned PIFO_ADDR_LSB  = 0;

    // One-hot bit order, MSB first: {CPU, NF3, NF2, NF1, NF0}
    localparam int unsigned PORT_NF0 = 0;
    localparam int unsigned PORT_NF1 = 1;
    localparam int unsigned PORT_NF2 = 2;
    localparam int unsigned PORT_NF3 = 3;
    localparam int unsigned PORT_CPU = 4;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr_i with an
// explicit wrap at N-1; the pointer register lives in the parent.
module rr_arbiter #(
    parameter int unsigned N     = 5,
    parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [PTR_W-1:0] grant_idx_o,
    output logic             grant_valid_o
);

    function automatic int unsigned wrap_idx(input int unsigned base, input int unsigned off);
        int unsigned s;
        s = base + off;
        return (s >= N) ? s - N : s;
    endfunction

    always_comb begin
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        for (int unsigned off = 0; off < N; off++) begin
            if (!grant_valid_o && req_i[PTR_W'(wrap_idx(int'(ptr_i), off))]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = PTR_W'(wrap_idx(int'(ptr_i), off));
            end
        end
    end

endmodule

// File: rtl/dequeue_scheduler.sv
// Round-robin dequeue scheduler: pops one PIFO head, then streams that packet
// from the shared buffer until EOP. Statistics counters exist only with DEQUEUE_STATS_EN.
module dequeue_scheduler
    import scheduler_pkg::*;
#(
    parameter int unsigned QUEUE_NUM       = 5,
    parameter int unsigned PIFO_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 12,
    parameter int unsigned PIFO_RD_LATENCY = 1
) (
    input  logic                            axis_aclk,
    input  logic                            axis_reset,
    input  logic [QUEUE_NUM-1:0]            s_pifo_empty,
    input  logic [QUEUE_NUM*PIFO_WIDTH-1:0] s_pifo_dout,
    output logic [QUEUE_NUM-1:0]            m_pifo_out_en,
    input  logic [QUEUE_NUM-1:0]            s_tx_ready,
    output logic [QUEUE_NUM-1:0]            m_buffer_rd_en,
    output logic [ADDR_WIDTH-1:0]           m_buffer_rd_addr,
    input  logic                            s_buffer_rd_valid,
    input  logic                            s_buffer_rd_last,
    output logic [QUEUE_NUM-1:0]            m_active_queue,
    output logic [QUEUE_NUM*32-1:0]         m_stat_pkt_cnt,
    output logic [31:0]                     m_stat_invalid_cnt
);

    localparam int unsigned PTR_W = (QUEUE_NUM > 1) ? $clog2(QUEUE_NUM) : 1;
    localparam int unsigned CNT_W = 2;

    sched_state_e          state_q, state_d;
    logic [PTR_W-1:0]      sel_q, sel_d, ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [QUEUE_NUM-1:0]  pop_q, pop_d, rd_en_q, rd_en_d, active_q, active_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

    logic [QUEUE_NUM-1:0]  eligible, sel_oh, grant_oh;
    logic [PTR_W-1:0]      grant_idx;
    logic                  grant_valid;
    logic                  head_valid;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic                  pkt_done, inv_hit;

    assign eligible = ~s_pifo_empty & s_tx_ready;
    assign sel_oh   = QUEUE_NUM'(1) << sel_q;
    assign grant_oh = QUEUE_NUM'(1) << grant_idx;

    rr_arbiter #(.N(QUEUE_NUM), .PTR_W(PTR_W)) u_arb (
        .req_i         (eligible),
        .ptr_i         (ptr_q),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    always_comb begin
        head_valid = 1'b0;
        head_addr  = '0;
        for (int unsigned i = 0; i < QUEUE_NUM; i++) begin
            if (sel_q == PTR_W'(i)) begin
                head_valid = s_pifo_dout[i*PIFO_WIDTH + PIFO_VALID_POS];
                head_addr  = s_pifo_dout[i*PIFO_WIDTH + PIFO_ADDR_LSB +: ADDR_WIDTH];
            end
        end
    end

    // Outputs are registered, so each state computes the value its successor presents.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        pop_d     = '0;
        rd_en_d   = rd_en_q;
        rd_addr_d = rd_addr_q;
        active_d  = active_q;
        pkt_done  = 1'b0;
        inv_hit   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                rd_en_d = '0;
                if (grant_valid) begin
                    sel_d   = grant_idx;
                    pop_d   = grant_oh;
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                cnt_d   = CNT_W'(PIFO_RD_LATENCY - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (head_valid) begin
                        rd_addr_d = head_addr;
                        active_d  = sel_oh;
                        rd_en_d   = sel_oh & {QUEUE_NUM{s_tx_ready[sel_q]}};
                        state_d   = ST_STREAM;
                    end else begin
                        inv_hit = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_STREAM: begin
                rd_en_d = sel_oh & {QUEUE_NUM{s_tx_ready[sel_q]}};
                if (s_buffer_rd_valid && s_buffer_rd_last) begin
                    rd_en_d  = '0;
                    active_d = '0;
                    pkt_done = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (pkt_done || inv_hit) begin
            ptr_d = (sel_q == PTR_W'(QUEUE_NUM - 1)) ? '0 : sel_q + 1'b1;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            pop_q     <= '0;
            rd_en_q   <= '0;
            rd_addr_q <= '0;
            active_q  <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            pop_q     <= pop_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            active_q  <= active_d;
        end
    end

    assign m_pifo_out_en    = pop_q;
    assign m_buffer_rd_en   = rd_en_q;
    assign m_buffer_rd_addr = rd_addr_q;
    assign m_active_queue   = active_q;

`ifdef DEQUEUE_STATS_EN
    logic [31:0] stat_q [QUEUE_NUM];
    logic [31:0] inv_q;

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            for (int unsigned i = 0; i < QUEUE_NUM; i++) begin
                stat_q[i] <= '0;
            end
            inv_q <= '0;
        end else begin
            if (pkt_done) begin
                stat_q[sel_q] <= sat_inc32(stat_q[sel_q]);
            end
            if (inv_hit) begin
                inv_q <= sat_inc32(inv_q);
            end
        end
    end

    always_comb begin
        m_stat_pkt_cnt = '0;
        for (int unsigned i = 0; i < QUEUE_NUM; i++) begin
            m_stat_pkt_cnt[i*32 +: 32] = stat_q[i];
        end
    end
    assign m_stat_invalid_cnt = inv_q;
`else
    assign m_stat_pkt_cnt     = '0;
    assign m_stat_invalid_cnt = '0;
`endif

endmodule

// File: tb/tb_dequeue_scheduler.sv
// Directed bench for dequeue_scheduler: PIFO and buffer models, a vector table
// of single-packet transactions, and sequences for backpressure, skipping, reset and fairness.
module tb_dequeue_scheduler;

    localparam int unsigned QN = 5;
    localparam int unsigned PW = 32;
    localparam int unsigned AW = 12;
    localparam int unsigned LAT = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [QN-1:0]     empty = '1;
    logic [QN-1:0]     tx_ready;
    logic [QN*PW-1:0]  dout = '0;
    logic [QN-1:0]     pop, rd_en, active;
    logic [AW-1:0]     rd_addr;
    logic              bv = 1'b0, bl = 1'b0;
    logic [QN*32-1:0]  stat;
    logic [31:0]       inv;

    dequeue_scheduler #(.QUEUE_NUM(QN), .PIFO_WIDTH(PW), .ADDR_WIDTH(AW), .PIFO_RD_LATENCY(LAT)) dut (
        .axis_aclk(clk), .axis_reset(rst), .s_pifo_empty(empty), .s_pifo_dout(dout),
        .m_pifo_out_en(pop), .s_tx_ready(tx_ready), .m_buffer_rd_en(rd_en),
        .m_buffer_rd_addr(rd_addr), .s_buffer_rd_valid(bv), .s_buffer_rd_last(bl),
        .m_active_queue(active), .m_stat_pkt_cnt(stat), .m_stat_invalid_cnt(inv)
    );

    // Second instance at read latency 3 with a trivial constant-head environment
    logic              l3_rst;
    logic [QN-1:0]     l3_empty, l3_tx, l3_pop, l3_rd_en, l3_active;
    logic [QN*PW-1:0]  l3_dout;
    logic [AW-1:0]     l3_addr;
    logic              l3_bv = 1'b0;
    logic [QN*32-1:0]  l3_stat;
    logic [31:0]       l3_inv;

    dequeue_scheduler #(.QUEUE_NUM(QN), .PIFO_WIDTH(PW), .ADDR_WIDTH(AW), .PIFO_RD_LATENCY(3)) u_lat3 (
        .axis_aclk(clk), .axis_reset(l3_rst), .s_pifo_empty(l3_empty), .s_pifo_dout(l3_dout),
        .m_pifo_out_en(l3_pop), .s_tx_ready(l3_tx), .m_buffer_rd_en(l3_rd_en),
        .m_buffer_rd_addr(l3_addr), .s_buffer_rd_valid(l3_bv), .s_buffer_rd_last(l3_bv),
        .m_active_queue(l3_active), .m_stat_pkt_cnt(l3_stat), .m_stat_invalid_cnt(l3_inv)
    );

    always @(posedge clk) l3_bv <= l3_rst ? 1'b0 : ((|l3_rd_en) && !l3_bv);

    // PIFO model: per-queue FIFO, head appears LAT cycles after the pop pulse
    logic [31:0] mem [QN][8];
    int unsigned wr [QN] = '{default: 0};
    int unsigned rd [QN] = '{default: 0};
    logic        pend_v [QN] = '{default: 1'b0};
    logic [31:0] pend_d [QN];
    int unsigned pend_c [QN];

    always @(posedge clk) begin
        for (int i = 0; i < QN; i++) begin
            if (pop[i] && rd[i] != wr[i]) begin
                pend_v[i] = 1'b1;
                pend_d[i] = mem[i][rd[i] % 8];
                pend_c[i] = LAT - 1;
                rd[i]++;
            end
            if (pend_v[i]) begin
                if (pend_c[i] == 0) begin
                    dout[i*PW +: PW] <= pend_d[i];
                    pend_v[i] = 1'b0;
                end else begin
                    pend_c[i]--;
                end
            end
            empty[i] <= (rd[i] == wr[i]);
        end
    end

    // Buffer model: each rd_en cycle returns one beat next cycle, up to blen beats
    int unsigned blen = 1;
    int unsigned bcnt = 0;
    always @(posedge clk) begin
        if (rst || active == '0) begin
            bv <= 1'b0; bl <= 1'b0; bcnt = 0;
        end else if (rd_en != '0 && bcnt < blen) begin
            bv <= 1'b1; bl <= (bcnt == blen - 1); bcnt++;
        end else begin
            bv <= 1'b0; bl <= 1'b0;
        end
    end

    int unsigned tests = 0, fails = 0, beats = 0;
    int unsigned exp_stat [QN] = '{default: 0};
    int unsigned exp_inv = 0;

    task automatic step();
        @(posedge clk); #1;
        if (bv) beats++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_stats(input string tag);
`ifdef DEQUEUE_STATS_EN
        for (int i = 0; i < QN; i++) chk({tag, "_stat"}, 64'(stat[i*32 +: 32]), 64'(exp_stat[i]));
        chk({tag, "_inv"}, 64'(inv), 64'(exp_inv));
`else
        chk({tag, "_stat_tied"}, 64'(|stat), 64'd0);
        chk({tag, "_inv_tied"}, 64'(inv), 64'd0);
`endif
    endtask

    task automatic push(input int unsigned q, input logic [31:0] e);
        mem[q][wr[q] % 8] = e;
        wr[q]++;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 100 && active != '0; k++) step();
        chk({tag, "_timeout"}, 64'(active), 64'd0);
    endtask

    typedef struct {
        int unsigned q;
        logic        valid;
        logic [18:0] rank;
        logic [11:0] addr;
        int unsigned beats;
        logic [4:0]  exp_pop;
        logic [4:0]  exp_rden;
        logic [11:0] exp_addr;
        int unsigned exp_beats;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [4:0]  pops [6];
        logic [4:0]  act_seen [6];
        logic [11:0] addr_seen [6];
        logic [4:0]  prev_act;
        int unsigned np, nrd, k3, n3, last3, cyc;

        vecs[0] = '{q:2, valid:1'b1, rank:19'd5, addr:12'h040, beats:3, exp_pop:5'b00100, exp_rden:5'b00100, exp_addr:12'h040, exp_beats:3};
        vecs[1] = '{q:0, valid:1'b1, rank:19'd9, addr:12'h123, beats:1, exp_pop:5'b00001, exp_rden:5'b00001, exp_addr:12'h123, exp_beats:1};
        vecs[2] = '{q:4, valid:1'b1, rank:19'd1, addr:12'hFFF, beats:4, exp_pop:5'b10000, exp_rden:5'b10000, exp_addr:12'hFFF, exp_beats:4};
        vecs[3] = '{q:3, valid:1'b0, rank:19'd7, addr:12'h055, beats:2, exp_pop:5'b01000, exp_rden:5'b00000, exp_addr:12'hFFF, exp_beats:0};
        vecs[4] = '{q:1, valid:1'b1, rank:19'd3, addr:12'h800, beats:2, exp_pop:5'b00010, exp_rden:5'b00010, exp_addr:12'h800, exp_beats:2};

        rst = 1'b1; l3_rst = 1'b1; tx_ready = '1;
        l3_empty = '1; l3_tx = '1; l3_dout = '0;
        l3_dout[31:0] = {1'b1, 19'd0, 12'h0AA};
        repeat (3) step();
        chk("rst_pop", 64'(pop), 64'd0);
        chk("rst_rden", 64'(rd_en), 64'd0);
        chk("rst_active", 64'(active), 64'd0);
        chk("rst_addr", 64'(rd_addr), 64'd0);
        chk_stats("rst");
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            blen = vecs[i].beats;
            beats = 0;
            push(vecs[i].q, {vecs[i].valid, vecs[i].rank, vecs[i].addr});
            step();
            chk("vec_no_early_pop", 64'(pop), 64'd0);
            step();
            chk("vec_pop", 64'(pop), 64'(vecs[i].exp_pop));
            step();
            chk("vec_pop_once", 64'(pop), 64'd0);
            chk("vec_no_early_rden", 64'(rd_en), 64'd0);
            step();
            chk("vec_rden", 64'(rd_en), 64'(vecs[i].exp_rden));
            chk("vec_active", 64'(active), 64'(vecs[i].exp_rden));
            chk("vec_addr", 64'(rd_addr), 64'(vecs[i].exp_addr));
            wait_idle("vec");
            step();
            chk("vec_beats", 64'(beats), 64'(vecs[i].exp_beats));
            if (vecs[i].valid) exp_stat[vecs[i].q]++; else exp_inv++;
            chk_stats("vec");
        end

        // Backpressure on queue 1 mid-packet
        blen = 8; beats = 0;
        push(1, {1'b1, 19'd2, 12'h321});
        repeat (4) step();
        chk("bp_first_rden", 64'(rd_en), 64'h02);
        repeat (2) step();
        tx_ready[1] = 1'b0;
        chk("bp_pre_stall", 64'(rd_en), 64'h02);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("bp_stall", 64'(rd_en), 64'd0);
            chk("bp_still_stream", 64'(active), 64'h02);
        end
        tx_ready[1] = 1'b1;
        step();
        chk("bp_resume", 64'(rd_en), 64'h02);
        wait_idle("bp");
        step();
        chk("bp_beats", 64'(beats), 64'd8);
        exp_stat[1]++;

        // Pointer now 2: invalid q3 is skipped, then q4, then q0 after wrap
        blen = 2; np = 0; nrd = 0; prev_act = '0;
        push(3, {1'b0, 19'd0, 12'h055});
        push(4, {1'b1, 19'd0, 12'h444});
        push(0, {1'b1, 19'd0, 12'h0A0});
        for (int k = 0; k < 300 && !(nrd == 2 && active == '0); k++) begin
            step();
            if (pop != '0 && np < 3) begin pops[np] = pop; np++; end
            if (active != '0 && prev_act == '0 && nrd < 2) begin
                act_seen[nrd] = active; addr_seen[nrd] = rd_addr; nrd++;
            end
            prev_act = active;
        end
        chk("inv_pop_count", 64'(np), 64'd3);
        chk("inv_rd_count", 64'(nrd), 64'd2);
        chk("inv_pop0", 64'(pops[0]), 64'h08);
        chk("inv_pop1", 64'(pops[1]), 64'h10);
        chk("inv_pop2", 64'(pops[2]), 64'h01);
        chk("inv_rd0", 64'(act_seen[0]), 64'h10);
        chk("inv_addr0", 64'(addr_seen[0]), 64'h444);
        chk("inv_rd1", 64'(act_seen[1]), 64'h01);
        chk("inv_addr1", 64'(addr_seen[1]), 64'h0A0);
        exp_inv++; exp_stat[4]++; exp_stat[0]++;
        chk_stats("inv");

        // Reset in the middle of a long packet
        blen = 10;
        push(2, {1'b1, 19'd0, 12'h2AB});
        repeat (6) step();
        chk("mid_rst_streaming", 64'(active), 64'h04);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_pop", 64'(pop), 64'd0);
        chk("mid_rst_rden", 64'(rd_en), 64'd0);
        chk("mid_rst_active", 64'(active), 64'd0);
        chk("mid_rst_addr", 64'(rd_addr), 64'd0);
        for (int i = 0; i < QN; i++) exp_stat[i] = 0;
        exp_inv = 0;
        chk_stats("mid_rst");
        repeat (3) step();
        chk("post_rst_idle", 64'(active | rd_en | pop), 64'd0);

        // Fairness from a freshly reset pointer
        blen = 2; np = 0; nrd = 0; prev_act = '0;
        push(0, {1'b1, 19'd0, 12'h010}); push(0, {1'b1, 19'd0, 12'h011});
        push(1, {1'b1, 19'd0, 12'h020}); push(1, {1'b1, 19'd0, 12'h021});
        push(4, {1'b1, 19'd0, 12'h040}); push(4, {1'b1, 19'd0, 12'h041});
        for (int k = 0; k < 400 && !(nrd == 6 && active == '0); k++) begin
            step();
            if (pop != '0 && np < 6) begin pops[np] = pop; np++; end
            if (active != '0 && prev_act == '0 && nrd < 6) begin
                act_seen[nrd] = active; addr_seen[nrd] = rd_addr; nrd++;
            end
            prev_act = active;
        end
        chk("fair_count", 64'(nrd), 64'd6);
        chk("fair_pop0", 64'(pops[0]), 64'h01);
        chk("fair_pop1", 64'(pops[1]), 64'h02);
        chk("fair_pop2", 64'(pops[2]), 64'h10);
        chk("fair_pop3", 64'(pops[3]), 64'h01);
        chk("fair_pop4", 64'(pops[4]), 64'h02);
        chk("fair_pop5", 64'(pops[5]), 64'h10);
        chk("fair_addr0", 64'(addr_seen[0]), 64'h010);
        chk("fair_addr2", 64'(addr_seen[2]), 64'h040);
        chk("fair_addr5", 64'(addr_seen[5]), 64'h041);
        exp_stat[0] += 2; exp_stat[1] += 2; exp_stat[4] += 2;
        chk_stats("fair");

        // Latency-3 instance: first rd_en at t+5, spacing 6, ten single-beat packets
        l3_rst = 1'b0;
        step();
        l3_empty = 5'b11110;
        k3 = 0;
        for (int k = 1; k <= 20 && k3 == 0; k++) begin
            step();
            if (l3_rd_en != '0) k3 = k;
        end
        chk("lat3_first_rden", 64'(k3), 64'd5);
        chk("lat3_addr", 64'(l3_addr), 64'h0AA);
        n3 = 0; last3 = 0; cyc = 0; prev_act = l3_rd_en;
        for (int k = 0; k < 300 && n3 < 10; k++) begin
            step();
            cyc++;
            if (l3_rd_en != '0 && prev_act == '0 && n3 > 0) chk("lat3_gap", 64'(cyc - last3), 64'd6);
            if (l3_bv) begin
                n3++; last3 = cyc;
                if (n3 == 10) l3_empty = '1;
            end
            prev_act = l3_rd_en;
        end
        chk("lat3_pkts", 64'(n3), 64'd10);
        repeat (10) step();
        chk("lat3_idle", 64'(l3_active | l3_rd_en | l3_pop), 64'd0);
`ifdef DEQUEUE_STATS_EN
        chk("lat3_stat0", 64'(l3_stat[31:0]), 64'd10);
        chk("lat3_stat_other", 64'(l3_stat[QN*32-1:32]), 64'd0);
        chk("lat3_inv", 64'(l3_inv), 64'd0);
`else
        chk("lat3_stat_tied", 64'(|l3_stat), 64'd0);
        chk("lat3_inv_tied", 64'(l3_inv), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
